// File: rtl/layer_engine_fix_pkg.sv
`default_nettype none
// ============================================================================
// Package     : layer_engine_pkg
// Description : Shared definitions for the fixed-point layer engine: FSM
//               state encoding, accumulator sizing and saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_engine_pkg;

    // Engine sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_MAC  = 3'd3,
        ST_POST = 3'd4
    } state_e;

    // Wide enough to hold (N_IN+1) full-scale products without wrapping
    function automatic int acc_width(input int width, input int n_in);
        return 2 * width + $clog2(n_in + 1);
    endfunction

    // Saturation limits of a signed WIDTH-bit result
    function automatic longint sat_hi(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage : layer_engine_pkg
`default_nettype wire

// File: rtl/layer_engine_fix_if.sv
`default_nettype none
// ============================================================================
// Interface   : layer_engine_fix_if
// Description : Weight-memory read bus. The engine (master) issues a read
//               strobe and address; the memory (slave) returns data exactly
//               one cycle after the strobe.
// Ports       : mem_rd   - read strobe          (master -> slave)
//               mem_addr - read address         (master -> slave)
//               mem_data - signed read data     (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_engine_fix_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                         mem_rd;
    logic        [ADDR_WIDTH-1:0] mem_addr;
    logic signed [WIDTH-1:0]      mem_data;

    modport master (output mem_rd, output mem_addr, input  mem_data);
    modport slave  (input  mem_rd, input  mem_addr, output mem_data);
endinterface : layer_engine_fix_if
`default_nettype wire

// File: rtl/layer_engine_fix_postproc.sv
`default_nettype none
// ============================================================================
// Module      : postproc_fix
// Description : Output stage for one neuron: scale, arithmetic shift,
//               optional ReLU and saturation to a signed WIDTH-bit value.
//               Purely combinational; the caller registers the result.
// Ports       : acc - signed accumulator input (ACC_W bits)
//               res - signed saturated result  (WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module postproc_fix
    import layer_engine_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_W     = 18,
    parameter int SCALE_MUL = 1,
    parameter int SHIFT     = 0,
    parameter int RELU_EN   = 1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [WIDTH-1:0] res
);
    // Room for a full 32-bit multiplier on top of the accumulator
    localparam int PROD_W = ACC_W + 33;
    localparam logic signed [PROD_W-1:0] c_hi = PROD_W'(sat_hi(WIDTH));
    localparam logic signed [PROD_W-1:0] c_lo = PROD_W'(sat_lo(WIDTH));

    logic signed [PROD_W-1:0] w_scaled;
    logic signed [PROD_W-1:0] w_shifted;
    logic signed [PROD_W-1:0] w_relu;

    assign w_scaled  = PROD_W'(acc) * PROD_W'(SCALE_MUL);
    assign w_shifted = w_scaled >>> SHIFT;
    assign w_relu    = ((RELU_EN != 0) && w_shifted[PROD_W-1]) ? '0 : w_shifted;

    always_comb begin
        res = w_relu[WIDTH-1:0];
        if (w_relu > c_hi) begin
            res = c_hi[WIDTH-1:0];
        end else if (w_relu < c_lo) begin
            res = c_lo[WIDTH-1:0];
        end
    end
endmodule : postproc_fix
`default_nettype wire

// File: rtl/layer_engine_fix.sv
`default_nettype none
// ============================================================================
// Module      : layer_engine_fix
// Description : Sequential fully-connected layer. For each row (bias row 0,
//               then one row per input) it streams N_OUT weights from memory,
//               then multiplies them by the row argument and accumulates into
//               N_OUT accumulators in one cycle. Results are post-processed
//               and registered once all rows are done.
// Ports       : clk, rst (async, active low), start, base_addr, x_in,
//               mem (weight read bus, master side), busy, out_valid, out
// Revision    : 1.0 - initial release
// ============================================================================
module layer_engine_fix
    import layer_engine_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int N_IN       = 25,
    parameter int N_OUT      = 10,
    parameter int BIAS_VAL   = 1,
    parameter int SCALE_MUL  = 1,
    parameter int SHIFT      = 0,
    parameter int RELU_EN    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [N_IN-1:0][WIDTH-1:0]       x_in,
    layer_engine_fix_if.master               mem,
    output logic                             busy,
    output logic                             out_valid,
    output logic [N_OUT-1:0][WIDTH-1:0]      out
);
    localparam int ACC_W = acc_width(WIDTH, N_IN);
    localparam int COL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int ROW_W = $clog2(N_IN + 2);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_LOAD = ST_LOAD;
    localparam logic [2:0] S_WAIT = ST_WAIT;
    localparam logic [2:0] S_MAC  = ST_MAC;
    localparam logic [2:0] S_POST = ST_POST;

    logic [2:0]                  r_state;
    logic [COL_W-1:0]            r_col;
    logic [ROW_W-1:0]            r_row;
    logic [ADDR_WIDTH-1:0]       r_base;
    logic [N_IN-1:0][WIDTH-1:0]  r_x;
    logic signed [WIDTH-1:0]     r_w   [N_OUT];
    logic signed [ACC_W-1:0]     r_acc [N_OUT];
    logic                        r_rd_d;
    logic                        r_out_valid;
    logic [N_OUT-1:0][WIDTH-1:0] r_out;

    logic                        w_load;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic signed [WIDTH-1:0]     w_arg;
    logic signed [2*WIDTH-1:0]   w_prod [N_OUT];
    logic signed [WIDTH-1:0]     w_post [N_OUT];

    assign w_load = (r_state == S_LOAD);
    // Truncation to ADDR_WIDTH gives the modulo-2^ADDR_WIDTH wrap
    assign w_addr = r_base + ADDR_WIDTH'(32'(r_row) * N_OUT + 32'(r_col));

    assign mem.mem_rd   = w_load;
    assign mem.mem_addr = w_load ? w_addr : '0;
    assign busy         = (r_state != S_IDLE);
    assign out_valid    = r_out_valid;
    assign out          = r_out;

    // Row 0 multiplies the bias constant, row r multiplies x[r-1]
    always_comb begin
        w_arg = WIDTH'(BIAS_VAL);
        for (int i = 0; i < N_IN; i++) begin
            if (32'(r_row) == 32'(i + 1)) begin
                w_arg = r_x[i];
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        assign w_prod[j] = (2*WIDTH)'(w_arg) * (2*WIDTH)'(r_w[j]);

        postproc_fix #(
            .WIDTH     (WIDTH),
            .ACC_W     (ACC_W),
            .SCALE_MUL (SCALE_MUL),
            .SHIFT     (SHIFT),
            .RELU_EN   (RELU_EN)
        ) u_post (
            .acc (r_acc[j]),
            .res (w_post[j])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_base      <= '0;
            r_x         <= '0;
            r_rd_d      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                r_w[j]   <= '0;
                r_acc[j] <= '0;
            end
        end else begin
            r_rd_d      <= w_load;
            r_out_valid <= 1'b0;

            // Read data trails the strobe by one cycle; the newest word enters
            // at the top so that after N_OUT shifts r_w[0] holds column 0.
            if (r_rd_d) begin
                for (int j = 0; j < N_OUT - 1; j++) begin
                    r_w[j] <= r_w[j+1];
                end
                r_w[N_OUT-1] <= mem.mem_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_x     <= x_in;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= S_LOAD;
                        for (int j = 0; j < N_OUT; j++) begin
                            r_acc[j] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_col == COL_W'(N_OUT - 1)) begin
                        r_col   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        r_acc[j] <= r_acc[j] + ACC_W'(w_prod[j]);
                    end
                    if (32'(r_row) < 32'(N_IN)) begin
                        r_row   <= r_row + 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_POST;
                    end
                end
                S_POST: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        r_out[j] <= w_post[j];
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule : layer_engine_fix
`default_nettype wire

// File: tb/tb_layer_engine_fix.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_engine_fix
// Description : Self-checking bench for layer_engine_fix with N_IN=2,
//               N_OUT=3. Two engines share all stimulus and one weight
//               memory; one has ReLU enabled, the other bypassed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_engine_fix;
    localparam int LAT = (2 + 1) * (3 + 2) + 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [15:0]    base_addr;
    logic [1:0][7:0] x_in;
    logic           busy_a, busy_b, out_valid_a, out_valid_b;
    logic [2:0][7:0] out_a, out_b;

    layer_engine_fix_if #(.WIDTH(8), .ADDR_WIDTH(16)) mem_a ();
    layer_engine_fix_if #(.WIDTH(8), .ADDR_WIDTH(16)) mem_b ();

    layer_engine_fix #(
        .WIDTH(8), .ADDR_WIDTH(16), .N_IN(2), .N_OUT(3), .BIAS_VAL(1),
        .SCALE_MUL(1), .SHIFT(0), .RELU_EN(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .x_in(x_in),
        .mem(mem_a), .busy(busy_a), .out_valid(out_valid_a), .out(out_a)
    );

    layer_engine_fix #(
        .WIDTH(8), .ADDR_WIDTH(16), .N_IN(2), .N_OUT(3), .BIAS_VAL(1),
        .SCALE_MUL(1), .SHIFT(0), .RELU_EN(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .x_in(x_in),
        .mem(mem_b), .busy(busy_b), .out_valid(out_valid_b), .out(out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory: data one cycle after the read strobe
    logic [7:0] wmem [0:65535];
    always @(posedge clk) begin
        if (mem_a.mem_rd) mem_a.mem_data <= wmem[mem_a.mem_addr];
        if (mem_b.mem_rd) mem_b.mem_data <= wmem[mem_b.mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int wts[9];
    int q_addr[$];
    int lat;
    int res_a[3];
    int res_b[3];
    bit vb_at_lat;

    task automatic store_wts(input int base);
        for (int k = 0; k < 9; k++) wmem[16'(base + k)] = 8'(wts[k]);
    endtask

    // Reference: out[j] = clamp(relu(1*W[0][j] + x0*W[1][j] + x1*W[2][j]))
    function automatic int model(input int j, input int x0, input int x1,
                                 input int base, input bit relu);
        int acc;
        acc = 1  * int'($signed(wmem[16'(base + j)]))
            + x0 * int'($signed(wmem[16'(base + 3 + j)]))
            + x1 * int'($signed(wmem[16'(base + 6 + j)]));
        if (relu && acc < 0) acc = 0;
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    // Pulses start, then follows the layer until out_valid or a cycle budget.
    // repulse >= 0 re-pulses start (with zeroed inputs) sampled at that edge.
    task automatic run_layer(input int x0, input int x1, input int base, input int repulse);
        x_in[0]   = 8'(x0);
        x_in[1]   = 8'(x1);
        base_addr = 16'(base);
        start     = 1'b1;
        q_addr.delete();
        lat       = -1;
        vb_at_lat = 1'b0;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (cyc == 0) start = 1'b0;
            if (repulse >= 0 && cyc == repulse - 1) begin
                start = 1'b1; x_in = '0; base_addr = '0;
            end
            if (repulse >= 0 && cyc == repulse) start = 1'b0;
            if (mem_a.mem_rd) q_addr.push_back(int'(mem_a.mem_addr));
            if (out_valid_a) begin
                lat = cyc;
                vb_at_lat = out_valid_b;
                for (int j = 0; j < 3; j++) begin
                    res_a[j] = int'($signed(out_a[j]));
                    res_b[j] = int'($signed(out_b[j]));
                end
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; base_addr = '0; x_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_a, busy_b, out_valid_a, out_valid_b, mem_a.mem_rd, mem_b.mem_rd} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000",
                {busy_a, busy_b, out_valid_a, out_valid_b, mem_a.mem_rd, mem_b.mem_rd});
        end
        n_cmp++;
        if ({mem_a.mem_addr, out_a, out_b} !== '0) begin
            n_err++; $display("FAIL reset_data: addr=%h out_a=%h out_b=%h want 0",
                mem_a.mem_addr, out_a, out_b);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        wts = '{1, 2, 3, 4, -5, 6, 7, 8, -9};
        store_wts(100);
        @(negedge clk);
        run_layer(2, -1, 100, -1);
        n_cmp++;
        if (lat !== LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (res_a[0] !== 2 || res_a[1] !== 0 || res_a[2] !== 24) begin
            n_err++; $display("FAIL basic_relu_out: got [%0d,%0d,%0d] want [2,0,24]", res_a[0], res_a[1], res_a[2]);
        end
        n_cmp++;
        if (!vb_at_lat || res_b[0] !== 2 || res_b[1] !== -16 || res_b[2] !== 24) begin
            n_err++; $display("FAIL basic_norelu_out: valid=%0b got [%0d,%0d,%0d] want [2,-16,24]",
                vb_at_lat, res_b[0], res_b[1], res_b[2]);
        end
        n_cmp++;
        if (q_addr.size() != 9) begin
            n_err++; $display("FAIL basic_addr_count: got %0d want 9", q_addr.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (q_addr[k] !== 100 + k) begin
                    n_err++; $display("FAIL basic_addr[%0d]: got %0d want %0d", k, q_addr[k], 100 + k);
                    break;
                end
            end
        end
        // out_valid is a single pulse and out holds afterwards
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || int'($signed(out_a[2])) !== 24) begin
            n_err++; $display("FAIL basic_hold: valid=%0b busy=%0b out2=%0d want 0 0 24",
                out_valid_a, busy_a, $signed(out_a[2]));
        end
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 9; k++) wts[k] = 127;
        store_wts(100);
        @(negedge clk);
        run_layer(127, 127, 100, -1);
        n_cmp++;
        if (res_a[0] !== 127 || res_a[1] !== 127 || res_a[2] !== 127 || res_b[1] !== 127) begin
            n_err++; $display("FAIL sat_pos: got a=[%0d,%0d,%0d] b1=%0d want 127",
                res_a[0], res_a[1], res_a[2], res_b[1]);
        end
        @(negedge clk);
        run_layer(-128, -128, 100, -1);
        n_cmp++;
        if (res_b[0] !== -128 || res_b[1] !== -128 || res_b[2] !== -128) begin
            n_err++; $display("FAIL sat_neg: got [%0d,%0d,%0d] want -128", res_b[0], res_b[1], res_b[2]);
        end
        n_cmp++;
        if (res_a[0] !== 0 || res_a[2] !== 0) begin
            n_err++; $display("FAIL sat_neg_relu: got [%0d,%0d] want 0", res_a[0], res_a[2]);
        end
    endtask

    task automatic test_ignore_start;
        wts = '{1, 2, 3, 4, -5, 6, 7, 8, -9};
        store_wts(100);
        @(negedge clk);
        run_layer(2, -1, 100, 5);
        n_cmp++;
        if (lat !== LAT || res_a[0] !== 2 || res_a[1] !== 0 || res_a[2] !== 24) begin
            n_err++; $display("FAIL ignore_start: lat=%0d got [%0d,%0d,%0d] want %0d [2,0,24]",
                lat, res_a[0], res_a[1], res_a[2], LAT);
        end
        n_cmp++;
        if (q_addr.size() != 9 || q_addr[8] !== 108 || q_addr[3] !== 103) begin
            n_err++; $display("FAIL ignore_start_addr: n=%0d want 9 addresses 100..108", q_addr.size());
        end
        // Engine must go back to IDLE rather than start a second layer
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL ignore_start_idle: busy=%0b want 0", busy_a); end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        x_in[0] = 8'd2; x_in[1] = 8'hFF; base_addr = 16'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, busy_b, out_valid_a, mem_a.mem_rd, mem_a.mem_addr, out_a, out_b} !== '0) begin
            n_err++; $display("FAIL reset_mid: busy=%0b rd=%0b addr=%0d out_a=%h out_b=%h want 0",
                busy_a, mem_a.mem_rd, mem_a.mem_addr, out_a, out_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_a || out_valid_b || busy_a) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL reset_discard: activity cycles=%0d want 0", seen); end
        // Start presented on the very first edge after release
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_layer(2, -1, 100, -1);
        n_cmp++;
        if (lat !== LAT || res_a[0] !== 2 || res_a[1] !== 0 || res_a[2] !== 24) begin
            n_err++; $display("FAIL reset_restart: lat=%0d got [%0d,%0d,%0d] want %0d [2,0,24]",
                lat, res_a[0], res_a[1], res_a[2], LAT);
        end
    endtask

    task automatic test_wrap;
        wts = '{1, 2, 3, 4, -5, 6, 7, 8, -9};
        store_wts(65534);
        @(negedge clk);
        run_layer(2, -1, 65534, -1);
        n_cmp++;
        if (q_addr.size() != 9) begin
            n_err++; $display("FAIL wrap_count: got %0d want 9", q_addr.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (q_addr[k] !== ((65534 + k) % 65536)) begin
                    n_err++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, q_addr[k], (65534 + k) % 65536);
                    break;
                end
            end
        end
        n_cmp++;
        if (res_b[0] !== 2 || res_b[1] !== -16 || res_b[2] !== 24) begin
            n_err++; $display("FAIL wrap_out: got [%0d,%0d,%0d] want [2,-16,24]", res_b[0], res_b[1], res_b[2]);
        end
    endtask

    task automatic test_random;
        int x0, x1, base, ea, eb;
        for (int it = 0; it < 8; it++) begin
            base = int'($urandom_range(0, 65535));
            for (int k = 0; k < 9; k++) wts[k] = int'($urandom_range(0, 255)) - 128;
            store_wts(base);
            x0 = int'($urandom_range(0, 255)) - 128;
            x1 = int'($urandom_range(0, 255)) - 128;
            @(negedge clk);
            run_layer(x0, x1, base, -1);
            n_cmp++;
            if (lat !== LAT || !vb_at_lat) begin
                n_err++; $display("FAIL rand_latency[%0d]: got %0d/%0b want %0d/1", it, lat, vb_at_lat, LAT);
            end
            for (int j = 0; j < 3; j++) begin
                ea = model(j, x0, x1, base, 1'b1);
                eb = model(j, x0, x1, base, 1'b0);
                n_cmp++;
                if (res_a[j] !== ea || res_b[j] !== eb) begin
                    n_err++; $display("FAIL rand_out[%0d][%0d]: got relu=%0d raw=%0d want relu=%0d raw=%0d",
                        it, j, res_a[j], res_b[j], ea, eb);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_ignore_start();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_layer_engine_fix
`default_nettype wire

// File: doc/layer_engine_fix.md
LAYER_ENGINE_FIX -- requirements
Module: layer_engine_fix

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning signed data and weight width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning weight memory address width.
REQ-003 SHALL have parameter N_IN, default 25, meaning input count, bias excluded.
REQ-004 SHALL have parameter N_OUT, default 10, meaning output neuron count.
REQ-005 SHALL have parameter BIAS_VAL, default 1, meaning the constant input used for row 0, the bias row.
REQ-006 SHALL have parameter SCALE_MUL, default 1, meaning the post-accumulation multiplier.
REQ-007 SHALL have parameter SHIFT, default 0, meaning the arithmetic right shift applied after SCALE_MUL.
REQ-008 SHALL have parameter RELU_EN, default 1, meaning ReLU is applied when 1 and bypassed when 0.
REQ-009 SHALL have port clk, input, 1 bit: the single clock.
REQ-010 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port start, input, 1 bit: a one-cycle request to begin a layer.
REQ-012 SHALL have port base_addr, input, ADDR_WIDTH bits: the address of weight row 0, column 0.
REQ-013 SHALL have port x_in, input, N_IN x WIDTH signed: the layer inputs.
REQ-014 SHALL have port mem_rd, output, 1 bit: the weight read strobe.
REQ-015 SHALL have port mem_addr, output, ADDR_WIDTH bits: the weight read address.
REQ-016 SHALL have port mem_data, input, WIDTH bits signed: read data, valid exactly 1 cycle after mem_rd.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking new results.
REQ-019 SHALL have port out, output, N_OUT x WIDTH signed: the layer results.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, WAIT, MAC and POST.
- IDLE -> LOAD on start.
- LOAD -> WAIT after N_OUT cycles.
- WAIT -> MAC after 1 cycle.
- MAC -> LOAD while row < N_IN, otherwise MAC -> POST.
- POST -> IDLE after 1 cycle.
REQ-021 SHALL, on start accepted in IDLE, latch x_in and base_addr, clear all accumulators, and set the row counter to 0.
REQ-022 SHALL ignore start while busy; the latched x_in and base_addr are unaffected.
REQ-023 SHALL, in LOAD, assert mem_rd with mem_addr = base_addr + row*N_OUT + col, for col = 0..N_OUT-1, on consecutive cycles.
REQ-024 SHALL shift each returned mem_data word into an N_OUT-entry weight register, so that the last word is captured in WAIT.
REQ-025 SHALL, in MAC, add arg*w[j] to acc[j] for all j in one cycle, where arg = BIAS_VAL for row 0 and x_in[row-1] otherwise.
REQ-026 SHALL size the accumulators as 2*WIDTH + clog2(N_IN+1) bits signed, so they never wrap internally.
REQ-027 SHALL, in POST, compute v = (acc*SCALE_MUL) >>> SHIFT, apply ReLU if RELU_EN, saturate to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1], and register the result to out.
REQ-028 SHALL assert out_valid for the cycle after POST; out holds its value until the next out_valid.
REQ-029 SHALL have a latency of exactly (N_IN+1)*(N_OUT+2)+1 cycles from start sampled to out_valid high.
REQ-030 SHALL drive mem_addr to 0 and mem_rd low outside LOAD.
REQ-031 SHALL wrap address arithmetic modulo 2^ADDR_WIDTH.

Reset
REQ-032 SHALL, while rst is low, force the state to IDLE and set busy, mem_rd, out_valid, mem_addr, all out entries, accumulators, weight registers and counters to 0, asynchronously.
REQ-033 SHALL discard a layer in progress when reset occurs mid-operation, with no out_valid pulse, and accept start on the first clock edge after reset release.

Structure
REQ-034 SHALL place the state enum, an accumulator-width function and saturation limit constants in package layer_engine_pkg.
REQ-035 SHALL implement scale, ReLU and saturation in sub-module postproc_fix, instanced N_OUT times.

Verification
All scenarios use N_IN=2, N_OUT=3, WIDTH=8, BIAS_VAL=1, SCALE_MUL=1, SHIFT=0, with weight rows [1,2,3], [4,-5,6] and [7,8,-9] at base_addr=100.
REQ-036 SHALL check: x=[2,-1], RELU_EN=1 -> out=[2,0,24]; out_valid 16 cycles after start; read addresses are 100..108 in order.
REQ-037 SHALL check: the same stimulus with RELU_EN=0 -> out=[2,-16,24].
REQ-038 SHALL check: all weights 127 and x=[127,127] -> out=[127,127,127]; with x=[-128,-128] and RELU_EN=0 -> out=[-128,-128,-128].
REQ-039 SHALL check: start re-pulsed at cycle 5 with x=[0,0] -> ignored; results equal those of REQ-036.
REQ-040 SHALL check: rst pulsed low at cycle 8 -> all outputs 0 immediately, no out_valid; a new start after release gives out=[2,0,24].
REQ-041 SHALL check: base_addr=65534 -> mem_addr wraps to 0..6 after 65535, per REQ-031.
